// File: rtl/fp_mul_pkg.sv
// Shared constants for the floating-point multiplier datapath: default widths,
// exponent bias and the bit positions inside the {overflow, underflow, inexact} flag word.
package fp_mul_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;
  localparam int EXP_BIAS   = (1 << (EXP_W_DEF - 1)) - 1;

  localparam int FLAG_W   = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

endpackage

// File: rtl/fp_round_inc.sv
// Conditional +1 on a W-bit fraction, built as a ripple chain of full adders;
// cout flags the all-ones fraction rolling over.
module fp_round_inc #(
  parameter int W = 23
) (
  input  logic [W-1:0] a,
  input  logic         inc,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = inc;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (1'b0),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[W];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the building block of the ripple-carry chains in the FP datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/fp_norm_round.sv
// FP multiplier back end: S1 normalises the raw product, S2 rounds and packs to IEEE-754.
// Define FP_NORM_ROUND_EN for round-to-nearest-even; the default build truncates.
module fp_norm_round
  import fp_mul_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_sign,
  input  logic signed [EXP_W+1:0] i_exp,
  input  logic [2*MANT_W-1:0]     i_mant,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [EXP_W+MANT_W-1:0] o_data,
  output logic [FLAG_W-1:0]       o_flags
);

  localparam int PROD_W  = 2 * MANT_W;
  localparam int FRAC_W  = MANT_W - 1;
  localparam int XW      = EXP_W + 2;
  localparam int DATA_W  = EXP_W + MANT_W;
  localparam int EXP_INF = (1 << EXP_W) - 1;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

  logic                 stall;
  logic                 norm_guard;
  logic                 norm_sticky;
  logic [FRAC_W-1:0]    norm_frac;
  logic signed [XW-1:0] norm_exp;

  logic                 s1_valid;
  logic                 s1_sign;
  logic                 s1_zero;
  logic                 s1_guard;
  logic                 s1_sticky;
  logic [FRAC_W-1:0]    s1_frac;
  logic signed [XW-1:0] s1_exp;

  logic [FRAC_W-1:0]    rnd_frac;
  logic signed [XW-1:0] rnd_exp;
  logic                 ovf;
  logic                 unf;
  logic [DATA_W-1:0]    pack_data;
  logic [FLAG_W-1:0]    pack_flags;

  logic                 s2_valid;
  logic [DATA_W-1:0]    s2_data;
  logic [FLAG_W-1:0]    s2_flags;

  assign stall   = s2_valid & ~i_ready;
  assign o_ready = ~stall;

  // The hidden bit is implicit once the product is aligned, so only the fraction is carried on.
  always_comb begin
    if (i_mant[PROD_W-1]) begin
      norm_frac   = i_mant[PROD_W-2 -: FRAC_W];
      norm_guard  = i_mant[PROD_W-1-MANT_W];
      norm_sticky = |i_mant[PROD_W-2-MANT_W:0];
      norm_exp    = i_exp + EXP_ONE;
    end else begin
      norm_frac   = i_mant[PROD_W-3 -: FRAC_W];
      norm_guard  = i_mant[PROD_W-2-MANT_W];
      norm_sticky = |i_mant[PROD_W-3-MANT_W:0];
      norm_exp    = i_exp;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= i_valid;
      s1_sign   <= i_sign;
      s1_zero   <= (i_mant == '0);
      s1_guard  <= norm_guard;
      s1_sticky <= norm_sticky;
      s1_frac   <= norm_frac;
      s1_exp    <= norm_exp;
    end
  end

`ifdef FP_NORM_ROUND_EN
  logic              round_up;
  logic              inc_cout;
  logic [FRAC_W-1:0] inc_sum;

  assign round_up = s1_guard & (s1_sticky | s1_frac[0]);

  fp_round_inc #(.W(FRAC_W)) u_round_inc (
    .a   (s1_frac),
    .inc (round_up),
    .sum (inc_sum),
    .cout(inc_cout)
  );

  // A carry out of the fraction means 1.11..1 became 10.0: renormalise to 1.0, bump the exponent.
  assign rnd_frac = inc_cout ? '0 : inc_sum;
  assign rnd_exp  = inc_cout ? s1_exp + EXP_ONE : s1_exp;
`else
  assign rnd_frac = s1_frac;
  assign rnd_exp  = s1_exp;
`endif

  assign ovf = int'(rnd_exp) >= EXP_INF;
  assign unf = int'(rnd_exp) <= 0;

  always_comb begin
    pack_data  = '0;
    pack_flags = '0;
    if (s1_zero) begin
      pack_data[DATA_W-1] = s1_sign;
    end else if (ovf) begin
      pack_data            = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      pack_flags[FLAG_OVF] = 1'b1;
      pack_flags[FLAG_INX] = 1'b1;
    end else if (unf) begin
      pack_data[DATA_W-1]  = s1_sign;
      pack_flags[FLAG_UNF] = 1'b1;
      pack_flags[FLAG_INX] = 1'b1;
    end else begin
      pack_data            = {s1_sign, rnd_exp[EXP_W-1:0], rnd_frac};
      pack_flags[FLAG_INX] = s1_guard | s1_sticky;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_flags <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_data  <= pack_data;
      s2_flags <= pack_flags;
    end
  end

  assign o_valid = s2_valid;
  assign o_data  = s2_data;
  assign o_flags = s2_flags;

endmodule
